// File: rtl/spiflash4x_responder.sv
// rtl/spiflash4x_responder.sv - QPI fast-read (0xEB) flash responder backed by a byte-wide memory port
module spiflash4x_responder #(
    parameter int DUMMY_CYCLES = 4,
    parameter int ADDR_WIDTH   = 24
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  spiflash4x_cs_n,
    input  logic [3:0]            spiflash4x_dq_in,
    output logic [3:0]            spiflash4x_dq_out,
    output logic                  spiflash4x_dq_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int          ADDR_NIBBLES  = ADDR_WIDTH / 4;
    localparam logic [4:0]  ADDR_LAST     = 5'(ADDR_NIBBLES - 1);
    localparam logic [4:0]  DUMMY_LAST    = 5'(DUMMY_CYCLES - 1);
    localparam logic [7:0]  CMD_QUAD_READ = 8'hEB;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [4:0]            cnt;
    logic [ADDR_WIDTH-1:0] shift;
    logic [7:0]            buffer;
    logic                  lo_next;
    logic [7:0]            cmd_byte;
    logic [ADDR_WIDTH-1:0] addr_full;
    logic [7:0]            cur_byte;
    logic                  addr_last;
    logic                  dummy_last;

    assign cmd_byte   = {shift[3:0], spiflash4x_dq_in};
    assign addr_full  = {shift[ADDR_WIDTH-5:0], spiflash4x_dq_in};
    // The byte returned for a read issued last cycle is used directly on the edge that captures it.
    assign cur_byte   = mem_rd ? mem_rdata : buffer;
    assign addr_last  = (cnt == ADDR_LAST);
    assign dummy_last = (cnt == DUMMY_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (spiflash4x_cs_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CMD;
                CMD:     next_state = (cmd_byte == CMD_QUAD_READ) ? ADDR : IGNORE;
                ADDR:    next_state = addr_last ? DUMMY : ADDR;
                DUMMY:   next_state = dummy_last ? DATA : DUMMY;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt               <= '0;
            shift             <= '0;
            buffer            <= '0;
            lo_next           <= 1'b0;
            mem_addr          <= '0;
            mem_rd            <= 1'b0;
            cmd_err           <= 1'b0;
            spiflash4x_dq_out <= 4'h0;
            spiflash4x_dq_oe  <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;
            cnt     <= (next_state != state) ? 5'd0 : cnt + 5'd1;
            if (spiflash4x_cs_n) begin
                // Abandon the transaction; any read in flight is dropped.
                spiflash4x_dq_out <= 4'h0;
                spiflash4x_dq_oe  <= 1'b0;
                lo_next           <= 1'b0;
            end else begin
                if (mem_rd) begin
                    buffer <= mem_rdata;
                end
                case (state)
                    IDLE: begin
                        shift <= ADDR_WIDTH'(spiflash4x_dq_in);
                    end
                    CMD: begin
                        if (cmd_byte != CMD_QUAD_READ) begin
                            cmd_err <= 1'b1;
                        end
                    end
                    ADDR: begin
                        shift <= addr_full;
                        if (addr_last) begin
                            mem_addr <= addr_full;
                            mem_rd   <= 1'b1;
                        end
                    end
                    DUMMY: begin
                        if (dummy_last) begin
                            spiflash4x_dq_out <= cur_byte[7:4];
                            spiflash4x_dq_oe  <= 1'b1;
                            lo_next           <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (lo_next) begin
                            spiflash4x_dq_out <= buffer[3:0];
                            mem_addr          <= mem_addr + ADDR_WIDTH'(1);
                            mem_rd            <= 1'b1;
                            lo_next           <= 1'b0;
                        end else begin
                            spiflash4x_dq_out <= cur_byte[7:4];
                            lo_next           <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spiflash4x_responder.sv
// tb/tb_spiflash4x_responder.sv - directed bench for spiflash4x_responder (4 and 2 dummy-cycle builds)
module tb_spiflash4x_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1;
    logic [3:0]  dq_in = 4'h0;

    logic [3:0]  dq_out4, dq_out2;
    logic        dq_oe4, dq_oe2;
    logic [23:0] mem_addr4, mem_addr2;
    logic        mem_rd4, mem_rd2;
    logic [7:0]  mem_rdata4 = 8'h00;
    logic [7:0]  mem_rdata2 = 8'h00;
    logic        busy4, busy2;
    logic        cmd_err4, cmd_err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spiflash4x_responder #(.DUMMY_CYCLES(4), .ADDR_WIDTH(24)) dut4 (
        .clock(clock), .reset_n(reset_n), .spiflash4x_cs_n(cs_n), .spiflash4x_dq_in(dq_in),
        .spiflash4x_dq_out(dq_out4), .spiflash4x_dq_oe(dq_oe4), .mem_addr(mem_addr4),
        .mem_rd(mem_rd4), .mem_rdata(mem_rdata4), .busy(busy4), .cmd_err(cmd_err4)
    );

    spiflash4x_responder #(.DUMMY_CYCLES(2), .ADDR_WIDTH(24)) dut2 (
        .clock(clock), .reset_n(reset_n), .spiflash4x_cs_n(cs_n), .spiflash4x_dq_in(dq_in),
        .spiflash4x_dq_out(dq_out2), .spiflash4x_dq_oe(dq_oe2), .mem_addr(mem_addr2),
        .mem_rd(mem_rd2), .mem_rdata(mem_rdata2), .busy(busy2), .cmd_err(cmd_err2)
    );

    // Memory holds memory[n] = n[7:0]; data appears during the cycle after the strobing edge.
    always @(negedge clock) begin
        if (mem_rd4) mem_rdata4 <= mem_addr4[7:0];
        if (mem_rd2) mem_rdata2 <= mem_addr2[7:0];
    end

    task automatic step(input logic cs, input logic [3:0] d);
        @(negedge clock);
        cs_n  = cs;
        dq_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
        step(1'b0, cmd[7:4]);
        step(1'b0, cmd[3:0]);
        for (int i = 5; i >= 0; i--) step(1'b0, a[4*i +: 4]);
    endtask

    task automatic check_read(input logic [23:0] a, input int nbytes);
        logic [7:0]  b;
        logic [3:0]  en;
        logic [23:0] ea;
        logic        eoe;
        logic        erd;
        int          j;
        send_header(8'hEB, a);
        n_checks++;
        if (mem_rd4 !== 1'b1 || mem_addr4 !== a) begin
            n_fail++;
            $display("FAIL read_issue_d4: mem_rd=%b mem_addr=%h, expected 1 %h", mem_rd4, mem_addr4, a);
        end
        n_checks++;
        if (mem_rd2 !== 1'b1 || mem_addr2 !== a) begin
            n_fail++;
            $display("FAIL read_issue_d2: mem_rd=%b mem_addr=%h, expected 1 %h", mem_rd2, mem_addr2, a);
        end
        for (int e = 9; e <= 11 + 2 * nbytes; e++) begin
            step(1'b0, 4'h0);
            eoe = (e >= 12);
            erd = (e >= 13) && (((e - 12) % 2) == 1);
            n_checks++;
            if (dq_oe4 !== eoe || mem_rd4 !== erd) begin
                n_fail++;
                $display("FAIL oe_rd_d4 edge %0d: dq_oe=%b mem_rd=%b, expected %b %b", e, dq_oe4, mem_rd4, eoe, erd);
            end
            if (e >= 12) begin
                j  = e - 12;
                b  = 8'(a + 24'(j / 2));
                en = ((j % 2) == 0) ? b[7:4] : b[3:0];
                ea = a + 24'((e >= 13) ? (e - 11) / 2 : 0);
                n_checks++;
                if (dq_out4 !== en || mem_addr4 !== ea) begin
                    n_fail++;
                    $display("FAIL data_d4 edge %0d: dq_out=%h mem_addr=%h, expected %h %h", e, dq_out4, mem_addr4, en, ea);
                end
            end
            eoe = (e >= 10);
            n_checks++;
            if (dq_oe2 !== eoe) begin
                n_fail++;
                $display("FAIL oe_d2 edge %0d: dq_oe=%b, expected %b", e, dq_oe2, eoe);
            end
            if (e >= 10 && (e - 10) < 2 * nbytes) begin
                j  = e - 10;
                b  = 8'(a + 24'(j / 2));
                en = ((j % 2) == 0) ? b[7:4] : b[3:0];
                n_checks++;
                if (dq_out2 !== en) begin
                    n_fail++;
                    $display("FAIL data_d2 edge %0d: dq_out=%h, expected %h", e, dq_out2, en);
                end
            end
        end
        step(1'b1, 4'h0);
        n_checks++;
        if (busy4 !== 1'b0 || dq_oe4 !== 1'b0 || dq_out4 !== 4'h0 || mem_rd4 !== 1'b0 || busy2 !== 1'b0 || dq_oe2 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_end: busy=%b dq_oe=%b dq_out=%h mem_rd=%b busy2=%b dq_oe2=%b, expected all 0",
                     busy4, dq_oe4, dq_out4, mem_rd4, busy2, dq_oe2);
        end
    endtask

    task automatic test_reset;
        step(1'b1, 4'h0);
        n_checks++;
        if (busy4 !== 1'b0 || dq_oe4 !== 1'b0 || dq_out4 !== 4'h0 || mem_rd4 !== 1'b0 || cmd_err4 !== 1'b0 || mem_addr4 !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_d4: busy=%b oe=%b out=%h rd=%b err=%b addr=%h, expected 0", busy4, dq_oe4, dq_out4, mem_rd4, cmd_err4, mem_addr4);
        end
        n_checks++;
        if (busy2 !== 1'b0 || dq_oe2 !== 1'b0 || mem_rd2 !== 1'b0 || mem_addr2 !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_d2: busy=%b oe=%b rd=%b addr=%h, expected 0", busy2, dq_oe2, mem_rd2, mem_addr2);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 4'h0);
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_release: busy=%b, expected 0", busy4);
        end
    endtask

    task automatic test_read;
        check_read(24'h000010, 3);
    endtask

    task automatic test_bad_cmd;
        int bad;
        step(1'b0, 4'h0);
        step(1'b0, 4'h3);
        n_checks++;
        if (cmd_err4 !== 1'b1 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_err_pulse: cmd_err=%b busy=%b, expected 1 1", cmd_err4, busy4);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'(i));
            if (cmd_err4 !== 1'b0 || dq_oe4 !== 1'b0 || mem_rd4 !== 1'b0 || busy4 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ignore_quiet: %0d bad cycles, expected 0", bad);
        end
        step(1'b1, 4'h0);
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_exit: busy=%b, expected 0", busy4);
        end
    endtask

    task automatic test_wrap;
        check_read(24'hFFFFFF, 2);
    endtask

    task automatic test_abort_addr;
        int rd_seen;
        rd_seen = 0;
        step(1'b0, 4'hE);
        if (mem_rd4 !== 1'b0) rd_seen++;
        step(1'b0, 4'hB);
        if (mem_rd4 !== 1'b0) rd_seen++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h5);
            if (mem_rd4 !== 1'b0) rd_seen++;
        end
        step(1'b1, 4'h0);
        if (mem_rd4 !== 1'b0) rd_seen++;
        n_checks++;
        if (rd_seen != 0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_addr: mem_rd cycles=%0d busy=%b, expected 0 0", rd_seen, busy4);
        end
        check_read(24'h000020, 2);
    endtask

    task automatic test_reset_mid_data;
        send_header(8'hEB, 24'h000030);
        for (int e = 9; e <= 13; e++) step(1'b0, 4'h0);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dq_oe4 !== 1'b0 || mem_rd4 !== 1'b0 || busy4 !== 1'b0 || dq_out4 !== 4'h0 || mem_addr4 !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mid_data: oe=%b rd=%b busy=%b out=%h addr=%h, expected 0", dq_oe4, mem_rd4, busy4, dq_out4, mem_addr4);
        end
        @(negedge clock);
        cs_n = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 4'h0);
        check_read(24'h000040, 2);
    endtask

    initial begin
        test_reset;
        test_read;
        test_bad_cmd;
        test_wrap;
        test_abort_addr;
        test_reset_mid_data;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spiflash4x_responder.md
SPIFLASH4X_RESPONDER -- requirements
Module: spiflash4x_responder

Interface
REQ-001 Parameter DUMMY_CYCLES, default 4, clock edges between the last address nibble and the first data nibble; legal range 2..15.
REQ-002 Parameter ADDR_WIDTH, default 24, byte-address width of the backing memory port.
REQ-003 clock  in  1  single clock for all logic; doubles as SPI SCLK; all sampling on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 spiflash4x_cs_n  in  1  chip select from the initiator, active-low.
REQ-006 spiflash4x_dq_in  in  4  quad data driven by the initiator: command, then address.
REQ-007 spiflash4x_dq_out  out  4  read-data nibble to the initiator.
REQ-008 spiflash4x_dq_oe  out  1  high while the block drives dq_out.
REQ-009 mem_addr  out  ADDR_WIDTH  byte address to the backing ROM/RAM.
REQ-010 mem_rd  out  1  one-cycle read strobe; the memory returns data one cycle later.
REQ-011 mem_rdata  in  8  read data, valid in the cycle after the cycle in which mem_rd is high.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 cmd_err  out  1  one-cycle pulse when an unsupported command is received.

Function
REQ-014 The block SHALL implement the QPI fast-read responder: all phases 4 bits/edge, MSB nibble first.
REQ-015 The states SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-016 IDLE -> CMD SHALL occur on the first edge sampling cs_n=0, and that edge SHALL capture command nibble 1.
REQ-017 CMD SHALL span 2 edges; command 0xEB -> ADDR; any other value -> IGNORE, with cmd_err high for exactly the following cycle.
REQ-018 ADDR SHALL span ADDR_WIDTH/4 edges (6 at default), shifting MSB nibble first.
REQ-019 On the last ADDR edge, mem_addr SHALL load the assembled address and mem_rd SHALL go high for one cycle.
REQ-020 mem_rdata SHALL be captured into a byte buffer on the edge following the mem_rd cycle.
REQ-021 DUMMY SHALL span DUMMY_CYCLES edges with dq_oe=0; on the last DUMMY edge, dq_out SHALL load buffer[7:4] and dq_oe SHALL go to 1.
REQ-022 In DATA, each edge SHALL alternate dq_out between buffer[3:0] and the next byte's [7:4], giving 2 edges per byte.
REQ-023 On each edge that loads a low nibble, mem_addr SHALL increment by 1 and mem_rd SHALL pulse, so the next byte is in the buffer before its high nibble is needed.
REQ-024 mem_addr SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-025 DATA SHALL continue indefinitely while cs_n=0.
REQ-026 IGNORE SHALL hold dq_oe=0 and issue no mem_rd.
REQ-027 Any edge sampling cs_n=1, in any state, SHALL force state to IDLE and set dq_oe=0, dq_out=0 and mem_rd=0 in the next cycle, abandoning the transaction.
REQ-028 If cs_n=1 and mem_rd occur on the same edge, the returned mem_rdata SHALL be discarded.
REQ-029 cs_n deassert and reassert on consecutive edges SHALL start a fresh transaction: the edge with cs_n=0 in IDLE is CMD nibble 1.

Reset
REQ-030 reset_n=0 SHALL immediately set state=IDLE, dq_out=0, dq_oe=0, mem_addr=0, mem_rd=0, busy=0, cmd_err=0, and clear the shift and buffer registers.
REQ-031 Reset during any phase, including DATA, SHALL abort the transaction; after release, the block SHALL wait for cs_n=0 in IDLE.

Verification
REQ-032 Read at 0x000010 with cmd 0xEB, memory[n]=n -> dq_oe rises after 8+4 edges; nibbles 1,0,1,1,1,2 are output; mem_addr steps 0x10, 0x11, 0x12.
REQ-033 Cmd 0x03 -> cmd_err single pulse; dq_oe stays 0 and mem_rd stays 0 until cs_n=1; busy drops the cycle after cs_n=1.
REQ-034 Read at 0xFFFFFF for 2 bytes -> mem_addr goes 0xFFFFFF then 0x000000; data is memory[0xFFFFFF] then memory[0].
REQ-035 cs_n raised mid-address (after edge 4) -> IDLE, no mem_rd; the next full transaction reads correctly.
REQ-036 reset_n pulsed low mid-DATA -> dq_oe=0 and mem_rd=0 immediately, busy=0; the next transaction is correct.
REQ-037 DUMMY_CYCLES=2 build: the same read as REQ-032 -> dq_oe rises after 8+2 edges with identical data.
